// File: rtl/ctr_steal_sched.sv
// ---------------------------------------------------------------------------
// ctr_steal_sched
//   Schedules involuntary counter-increment cycles (PINC/MINC) that steal the
//   shared erasable-memory/ALU datapath from the instruction decoder between
//   instructions. Increment pulses are held in per-counter saturating pending
//   counts (P and M, 2 bits each), arbitrated by fixed priority (lowest index,
//   P before M), issued one per instruction boundary and retired on the
//   datapath's done strobe.
//
// Build option:
//   CTR_CASCADE_EN  when defined, an overflow of counter i < NUM_CTR-1 raises
//                   a pending request in the same direction on counter i+1
//                   instead of pulsing ovf_pulse. Top-counter overflow pulses.
//
// Ports:
//   clock        in   single clock, rising edge
//   rst_l        in   asynchronous active-low reset
//   inc_p/inc_m  in   [NUM_CTR] 1-cycle PINC/MINC request pulses
//   instr_bound  in   decoder at an instruction boundary
//   seq_hold     in   decoder mid-sequence, no steal allowed
//   steal_done   in   datapath wrote the stolen counter update
//   steal_ovf    in   counter overflowed (qualified by steal_done)
//   lost_clr     in   clears inc_lost
//   steal        out  steal cycle in progress, decoder holds fetch
//   steal_addr   out  [12] erasable address of the counter being updated
//   steal_minc   out  0 = PINC, 1 = MINC
//   ovf_pulse    out  1-cycle overflow report
//   ovf_idx      out  [4] counter index for ovf_pulse
//   inc_lost     out  sticky: request arrived on a saturated pending count
// ---------------------------------------------------------------------------
module ctr_steal_sched #(
    parameter int unsigned NUM_CTR  = 4,
    parameter logic [11:0] CTR_BASE = 12'o24
) (
    input  logic               clock,
    input  logic               rst_l,
    input  logic [NUM_CTR-1:0] inc_p,
    input  logic [NUM_CTR-1:0] inc_m,
    input  logic               instr_bound,
    input  logic               seq_hold,
    input  logic               steal_done,
    input  logic               steal_ovf,
    input  logic               lost_clr,
    output logic               steal,
    output logic [11:0]        steal_addr,
    output logic               steal_minc,
    output logic               ovf_pulse,
    output logic [3:0]         ovf_idx,
    output logic               inc_lost
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEAL   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Saturating pending-count update; returns {lost, next_count}.
    function automatic logic [2:0] f_pend_next(input logic [1:0] cur,
                                               input logic       inc_a,
                                               input logic       inc_b,
                                               input logic       dec);
        logic [2:0] sum;
        sum = {1'b0, cur} + {2'b00, inc_a} + {2'b00, inc_b} - {2'b00, dec};
        if (sum > 3'd3) begin
            return 3'b111;
        end else begin
            return {1'b0, sum[1:0]};
        end
    endfunction

    state_t       r_state;
    logic [1:0]   r_pend_p [NUM_CTR];
    logic [1:0]   r_pend_m [NUM_CTR];
    logic [3:0]   r_idx;
    logic         r_dir;
    logic         r_steal;
    logic [11:0]  r_steal_addr;
    logic         r_steal_minc;
    logic         r_ovf_pulse;
    logic [3:0]   r_ovf_idx;
    logic         r_inc_lost;

    logic         w_any;
    logic [3:0]   w_win_idx;
    logic         w_win_dir;
    logic         w_launch;
    logic         w_retire;
    logic         w_ovf_ev;
    logic         w_ovf_rpt;
    logic         w_lost;
    logic [NUM_CTR-1:0] w_cas_p;
    logic [NUM_CTR-1:0] w_cas_m;
    logic [2:0]   w_np_p [NUM_CTR];
    logic [2:0]   w_np_m [NUM_CTR];

    assign w_retire = (r_state == ST_STEAL) && steal_done;
    assign w_ovf_ev = w_retire && steal_ovf;
    assign w_launch = instr_bound && !seq_hold && w_any;

`ifdef CTR_CASCADE_EN
    // Only the top counter reports overflow; lower ones carry into i+1.
    assign w_ovf_rpt = w_ovf_ev && (r_idx == 4'(NUM_CTR - 1));
`else
    assign w_ovf_rpt = w_ovf_ev;
`endif

    // Fixed-priority arbiter: scan high to low so the lowest index wins.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = 4'd0;
        w_win_dir = 1'b0;
        for (int i = int'(NUM_CTR) - 1; i >= 0; i--) begin
            logic v_hit;
            v_hit     = (r_pend_p[i] != 2'd0) || (r_pend_m[i] != 2'd0);
            w_any     = w_any | v_hit;
            w_win_idx = v_hit ? 4'(i) : w_win_idx;
            w_win_dir = v_hit ? (r_pend_p[i] == 2'd0) : w_win_dir;
        end
    end

    // Overflow carry requests into the next counter (empty when cascade is off).
    always_comb begin
        w_cas_p = {NUM_CTR{1'b0}};
        w_cas_m = {NUM_CTR{1'b0}};
`ifdef CTR_CASCADE_EN
        for (int i = 1; i < int'(NUM_CTR); i++) begin
            w_cas_p[i] = w_ovf_ev && (r_idx == 4'(i - 1)) && !r_dir;
            w_cas_m[i] = w_ovf_ev && (r_idx == 4'(i - 1)) && r_dir;
        end
`endif
    end

    // Next pending counts: new pulses and carries add, retirement of the latched count subtracts.
    always_comb begin
        w_lost = 1'b0;
        for (int i = 0; i < int'(NUM_CTR); i++) begin
            w_np_p[i] = f_pend_next(r_pend_p[i], inc_p[i], w_cas_p[i],
                                    w_retire && (r_idx == 4'(i)) && !r_dir);
            w_np_m[i] = f_pend_next(r_pend_m[i], inc_m[i], w_cas_m[i],
                                    w_retire && (r_idx == 4'(i)) && r_dir);
            w_lost    = w_lost | w_np_p[i][2] | w_np_m[i][2];
        end
    end

    // Pending-count registers.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < int'(NUM_CTR); i++) begin
                r_pend_p[i] <= 2'd0;
                r_pend_m[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CTR); i++) begin
                r_pend_p[i] <= w_np_p[i][1:0];
                r_pend_m[i] <= w_np_m[i][1:0];
            end
        end
    end

    // Sticky lost-request flag; a new loss wins over a simultaneous clear.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            r_inc_lost <= 1'b0;
        end else if (w_lost) begin
            r_inc_lost <= 1'b1;
        end else if (lost_clr) begin
            r_inc_lost <= 1'b0;
        end else begin
            r_inc_lost <= r_inc_lost;
        end
    end

    // Steal FSM with registered outputs. RECOVER may launch the next steal
    // directly so back-to-back steals are separated by exactly one idle cycle.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_dir        <= 1'b0;
            r_steal      <= 1'b0;
            r_steal_addr <= 12'd0;
            r_steal_minc <= 1'b0;
            r_ovf_pulse  <= 1'b0;
            r_ovf_idx    <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RECOVER: begin
                    r_ovf_pulse <= 1'b0;
                    if (w_launch) begin
                        r_state      <= ST_STEAL;
                        r_idx        <= w_win_idx;
                        r_dir        <= w_win_dir;
                        r_steal      <= 1'b1;
                        r_steal_addr <= CTR_BASE + {8'd0, w_win_idx};
                        r_steal_minc <= w_win_dir;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STEAL: begin
                    if (steal_done) begin
                        r_state     <= ST_RECOVER;
                        r_steal     <= 1'b0;
                        r_ovf_pulse <= w_ovf_rpt;
                        r_ovf_idx   <= w_ovf_rpt ? r_idx : r_ovf_idx;
                    end else begin
                        r_state <= ST_STEAL;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_steal     <= 1'b0;
                    r_ovf_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign steal      = r_steal;
    assign steal_addr = r_steal_addr;
    assign steal_minc = r_steal_minc;
    assign ovf_pulse  = r_ovf_pulse;
    assign ovf_idx    = r_ovf_idx;
    assign inc_lost   = r_inc_lost;

endmodule

// File: tb/tb_ctr_steal_sched.sv
// ---------------------------------------------------------------------------
// tb_ctr_steal_sched
//   Directed bench for ctr_steal_sched (NUM_CTR=4, CTR_BASE=12'o24).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at the same point, i.e. they show the state loaded by that edge.
// ---------------------------------------------------------------------------
module tb_ctr_steal_sched;

    logic        clock = 1'b0;
    logic        rst_l;
    logic [3:0]  inc_p;
    logic [3:0]  inc_m;
    logic        instr_bound;
    logic        seq_hold;
    logic        steal_done;
    logic        steal_ovf;
    logic        lost_clr;
    logic        steal;
    logic [11:0] steal_addr;
    logic        steal_minc;
    logic        ovf_pulse;
    logic [3:0]  ovf_idx;
    logic        inc_lost;

    int err_cnt = 0;
    int chk_cnt = 0;

    ctr_steal_sched #(.NUM_CTR(4), .CTR_BASE(12'o24)) u_dut (
        .clock       (clock),
        .rst_l       (rst_l),
        .inc_p       (inc_p),
        .inc_m       (inc_m),
        .instr_bound (instr_bound),
        .seq_hold    (seq_hold),
        .steal_done  (steal_done),
        .steal_ovf   (steal_ovf),
        .lost_clr    (lost_clr),
        .steal       (steal),
        .steal_addr  (steal_addr),
        .steal_minc  (steal_minc),
        .ovf_pulse   (ovf_pulse),
        .ovf_idx     (ovf_idx),
        .inc_lost    (inc_lost)
    );

    // 10-unit clock period.
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Retire the current steal with a one-cycle done strobe.
    task automatic finish_steal(input logic ovf);
        steal_done = 1'b1;
        steal_ovf  = ovf;
        step();
        steal_done = 1'b0;
        steal_ovf  = 1'b0;
    endtask

    initial begin
        int n;
        int n_ovf;
        int bad;

        rst_l = 1'b0; inc_p = 4'd0; inc_m = 4'd0; instr_bound = 1'b0;
        seq_hold = 1'b0; steal_done = 1'b0; steal_ovf = 1'b0; lost_clr = 1'b0;
        step();
        step();
        check_val("rst_steal",   {31'd0, steal},      32'd0);
        check_val("rst_addr",    {20'd0, steal_addr}, 32'd0);
        check_val("rst_ovf",     {31'd0, ovf_pulse},  32'd0);
        check_val("rst_lost",    {31'd0, inc_lost},   32'd0);
        rst_l = 1'b1;
        step();

        // 1: fill counter 3 to saturation, start a steal, reset mid-steal.
        inc_p = 4'b1000;
        repeat (4) step();
        inc_p = 4'd0;
        check_val("t1_lost_set", {31'd0, inc_lost}, 32'd1);
        instr_bound = 1'b1;
        step();
        instr_bound = 1'b0;
        check_val("t1_steal",    {31'd0, steal},      32'd1);
        check_val("t1_addr",     {20'd0, steal_addr}, 32'o27);
        #2 rst_l = 1'b0;
        #1;
        check_val("t1_rst_steal", {31'd0, steal},     32'd0);
        check_val("t1_rst_ovf",   {31'd0, ovf_pulse}, 32'd0);
        check_val("t1_rst_lost",  {31'd0, inc_lost},  32'd0);
        step();
        rst_l = 1'b1;
        instr_bound = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n += int'(steal);
        end
        instr_bound = 1'b0;
        check_val("t1_no_steal_after", n, 32'd0);

        // 2: single PINC on counter 2, boundary three cycles later.
        inc_p = 4'b0100;
        step();
        inc_p = 4'd0;
        step();
        step();
        instr_bound = 1'b1;
        step();
        instr_bound = 1'b0;
        check_val("t2_steal", {31'd0, steal},      32'd1);
        check_val("t2_addr",  {20'd0, steal_addr}, 32'o26);
        check_val("t2_minc",  {31'd0, steal_minc}, 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!(steal === 1'b1 && steal_addr === 12'o26)) bad++;
        end
        check_val("t2_hold", bad, 32'd0);
        finish_steal(1'b0);
        check_val("t2_recover", {31'd0, steal}, 32'd0);
        instr_bound = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n += int'(steal);
        end
        instr_bound = 1'b0;
        check_val("t2_no_more", n, 32'd0);

        // 3: simultaneous MINC[3] and PINC[1]; boundary held high.
        inc_m = 4'b1000;
        inc_p = 4'b0010;
        step();
        inc_m = 4'd0;
        inc_p = 4'd0;
        instr_bound = 1'b1;
        step();
        check_val("t3_first_addr", {20'd0, steal_addr}, 32'o25);
        check_val("t3_first_minc", {31'd0, steal_minc}, 32'd0);
        check_val("t3_first_on",   {31'd0, steal},      32'd1);
        finish_steal(1'b0);
        check_val("t3_gap", {31'd0, steal}, 32'd0);
        step();
        check_val("t3_second_on",   {31'd0, steal},      32'd1);
        check_val("t3_second_addr", {20'd0, steal_addr}, 32'o27);
        check_val("t3_second_minc", {31'd0, steal_minc}, 32'd1);
        finish_steal(1'b0);
        step();
        check_val("t3_idle", {31'd0, steal}, 32'd0);
        instr_bound = 1'b0;

        // 4: seq_hold blocks the steal; stray done/ovf while idle are ignored.
        inc_p = 4'b0001;
        step();
        inc_p = 4'd0;
        instr_bound = 1'b1;
        seq_hold = 1'b1;
        n = 0;
        n_ovf = 0;
        for (int i = 0; i < 5; i++) begin
            steal_done = (i == 0);
            steal_ovf  = (i == 0);
            step();
            n     += int'(steal);
            n_ovf += int'(ovf_pulse);
        end
        steal_done = 1'b0;
        steal_ovf  = 1'b0;
        check_val("t4_held",     n,     32'd0);
        check_val("t4_stray_ovf", n_ovf, 32'd0);
        seq_hold = 1'b0;
        step();
        check_val("t4_steal", {31'd0, steal},      32'd1);
        check_val("t4_addr",  {20'd0, steal_addr}, 32'o24);
        finish_steal(1'b0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n += int'(steal);
        end
        instr_bound = 1'b0;
        check_val("t4_single", n, 32'd0);

        // 5: four PINC[0] pulses saturate the count at 3 and set inc_lost.
        inc_p = 4'b0001;
        repeat (4) step();
        inc_p = 4'd0;
        check_val("t5_lost", {31'd0, inc_lost}, 32'd1);
        instr_bound = 1'b1;
        n = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (steal === 1'b1) begin
                n++;
                if (steal_addr !== 12'o24) bad++;
            end
            steal_done = steal;
        end
        steal_done = 1'b0;
        instr_bound = 1'b0;
        check_val("t5_steal_count", n,   32'd3);
        check_val("t5_steal_addr",  bad, 32'd0);
        check_val("t5_lost_sticky", {31'd0, inc_lost}, 32'd1);
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        check_val("t5_lost_clr", {31'd0, inc_lost}, 32'd0);

        // 6: overflow on counter 0.
        inc_p = 4'b0001;
        step();
        inc_p = 4'd0;
        instr_bound = 1'b1;
        step();
        check_val("t6_steal", {31'd0, steal},      32'd1);
        check_val("t6_addr",  {20'd0, steal_addr}, 32'o24);
        finish_steal(1'b1);
`ifdef CTR_CASCADE_EN
        check_val("t6_no_pulse", {31'd0, ovf_pulse}, 32'd0);
        step();
        check_val("t6_cas_steal", {31'd0, steal},      32'd1);
        check_val("t6_cas_addr",  {20'd0, steal_addr}, 32'o25);
        check_val("t6_cas_minc",  {31'd0, steal_minc}, 32'd0);
        finish_steal(1'b0);
        check_val("t6_cas_no_pulse", {31'd0, ovf_pulse}, 32'd0);
`else
        check_val("t6_pulse", {31'd0, ovf_pulse}, 32'd1);
        check_val("t6_idx",   {28'd0, ovf_idx},   32'd0);
        step();
        check_val("t6_pulse_end", {31'd0, ovf_pulse}, 32'd0);
        check_val("t6_no_follow", {31'd0, steal},     32'd0);
`endif
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n += int'(steal);
        end
        instr_bound = 1'b0;
        check_val("t6_quiet", n, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
